// File: rtl/poco_led_ctrl.sv
// Memory-mapped LED controller: NCH channels, static/blink/invert, registered read-back.
// Latency: register writes commit on the write edge, led follows one cycle later; reads return one cycle after rd_en.
// Backpressure: none, one access per cycle always accepted. LED_CTRL_PWM_EN adds per-channel PWM with a DUTY register.
module poco_led_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFFF0,
    parameter int                NCH       = 2,
    parameter int                LED_W     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   we,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [NCH*LED_W-1:0]   led
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NREG = 4 * NCH;

    logic [ADDR_W-1:0]      off;
    logic                   in_win;
    logic [CH_W-1:0]        sel_ch;
    logic [1:0]             sel_reg;
    logic [CH_W+1:0]        rd_idx;
    logic [NREG*DATA_W-1:0] rd_all;

    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign off     = addr - BASE_ADDR;
    assign in_win  = off < ADDR_W'(NREG);
    assign sel_ch  = off[CH_W+1:2];
    assign sel_reg = off[1:0];
    assign rd_idx  = off[CH_W+1:0];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [LED_W-1:0]  data_q;
        logic              blink_q;
        logic              inv_q;
        logic [DATA_W-1:0] period_q;
        logic [DATA_W-1:0] cnt_q;
        logic              phase_q;
        logic [LED_W-1:0]  term;
        logic [LED_W-1:0]  led_q;
        logic              hit;
        logic              restart;
        logic              wrap;
`ifdef LED_CTRL_PWM_EN
        logic              pwm_q;
        logic [DATA_W-1:0] duty_q;
`endif

        assign hit     = we && in_win && (sel_ch == CH_W'(c));
        assign restart = hit && (sel_reg != 2'd0);
        assign wrap    = (cnt_q == period_q);

        always_comb begin
            term = data_q;
            if (blink_q) begin
`ifdef LED_CTRL_PWM_EN
                if (pwm_q)
                    term = (cnt_q < duty_q) ? data_q : '0;
                else
                    term = phase_q ? data_q : '0;
`else
                term = phase_q ? data_q : '0;
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q   <= '0;
                blink_q  <= 1'b0;
                inv_q    <= 1'b0;
                period_q <= '0;
                cnt_q    <= '0;
                phase_q  <= 1'b1;
                led_q    <= '0;
`ifdef LED_CTRL_PWM_EN
                pwm_q    <= 1'b0;
                duty_q   <= '0;
`endif
            end else begin
                if (hit) begin
                    case (sel_reg)
                        2'd0: data_q <= wdata[LED_W-1:0];
                        2'd1: begin
                            blink_q <= wdata[0];
                            inv_q   <= wdata[1];
`ifdef LED_CTRL_PWM_EN
                            pwm_q   <= wdata[2];
`endif
                        end
                        2'd2: period_q <= wdata;
`ifdef LED_CTRL_PWM_EN
                        default: duty_q <= wdata;
`else
                        default: ;
`endif
                    endcase
                end

                // A restart beats a wrap landing on the same edge.
                if (restart || !blink_q) begin
                    cnt_q   <= '0;
                    phase_q <= 1'b1;
                end else if (wrap) begin
                    cnt_q <= '0;
`ifdef LED_CTRL_PWM_EN
                    if (!pwm_q)
                        phase_q <= ~phase_q;
`else
                    phase_q <= ~phase_q;
`endif
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end

                led_q <= term ^ {LED_W{inv_q}};
            end
        end

        assign rd_all[(4*c+0)*DATA_W +: DATA_W] = DATA_W'(data_q);
        assign rd_all[(4*c+2)*DATA_W +: DATA_W] = period_q;
`ifdef LED_CTRL_PWM_EN
        assign rd_all[(4*c+1)*DATA_W +: DATA_W] = DATA_W'({pwm_q, inv_q, blink_q});
        assign rd_all[(4*c+3)*DATA_W +: DATA_W] = {duty_q[DATA_W-2:0], phase_q};
`else
        assign rd_all[(4*c+1)*DATA_W +: DATA_W] = DATA_W'({inv_q, blink_q});
        assign rd_all[(4*c+3)*DATA_W +: DATA_W] = DATA_W'(phase_q);
`endif
        assign led[c*LED_W +: LED_W] = led_q;
    end

    // Sampled before this edge's write lands, so a same-cycle read sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= in_win ? rd_all[rd_idx*DATA_W +: DATA_W] : '0;
        end
    end

endmodule

// File: tb/tb_poco_led_ctrl.sv
// Bench for poco_led_ctrl: directed plan steps, then random bus traffic against an arithmetic reference model.
module tb_poco_led_ctrl;
    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 16;
    localparam int          NCH    = 2;
    localparam int          LED_W  = 12;
    localparam logic [15:0] BASE   = 16'hFFF0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic                 we;
    logic                 rd_en;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic [NCH*LED_W-1:0] led;

    always #5 clk = ~clk;

    poco_led_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NCH(NCH), .LED_W(LED_W)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .led(led)
    );

    int errors = 0;
    int checks = 0;
    longint ecnt = 0;

    // Reference: registers plus the edge index of the last restart; counter/phase derived arithmetically.
    logic [LED_W-1:0]  m_data   [NCH];
    bit                m_blink  [NCH];
    bit                m_inv    [NCH];
    bit                m_pwm    [NCH];
    logic [DATA_W-1:0] m_period [NCH];
    logic [DATA_W-1:0] m_duty   [NCH];
    longint            m_start  [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_data[c] = '0; m_blink[c] = 0; m_inv[c] = 0; m_pwm[c] = 0;
            m_period[c] = '0; m_duty[c] = '0; m_start[c] = ecnt;
        end
    endfunction

    function automatic longint m_cnt(input int c, input longint e);
        if (!m_blink[c]) return 0;
        return (e - m_start[c]) % (longint'(m_period[c]) + 1);
    endfunction

    function automatic bit m_phase(input int c, input longint e);
        if (!m_blink[c] || m_pwm[c]) return 1'b1;
        return (((e - m_start[c]) / (longint'(m_period[c]) + 1)) % 2) == 0;
    endfunction

    function automatic logic [LED_W-1:0] m_led(input int c, input longint e);
        logic [LED_W-1:0] t;
        if (!m_blink[c])   t = m_data[c];
        else if (m_pwm[c]) t = (m_cnt(c, e) < longint'(m_duty[c])) ? m_data[c] : '0;
        else               t = m_phase(c, e) ? m_data[c] : '0;
        return m_inv[c] ? ~t : t;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a, input longint e);
        logic [15:0] off;
        int c;
        off = a - BASE;
        if (off >= 16'(4*NCH)) return 16'h0000;
        c = int'(off) / 4;
        case (off[1:0])
            2'd0:    return {4'h0, m_data[c]};
            2'd1:    return {13'h0, m_pwm[c], m_inv[c], m_blink[c]};
            2'd2:    return m_period[c];
`ifdef LED_CTRL_PWM_EN
            default: return {m_duty[c][14:0], m_phase(c, e)};
`else
            default: return {15'h0, m_phase(c, e)};
`endif
        endcase
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [15:0] d, input longint e);
        logic [15:0] off;
        int c;
        off = a - BASE;
        if (off >= 16'(4*NCH)) return;
        c = int'(off) / 4;
        case (off[1:0])
            2'd0: m_data[c] = d[11:0];
            2'd1: begin
                m_blink[c] = d[0]; m_inv[c] = d[1];
`ifdef LED_CTRL_PWM_EN
                m_pwm[c] = d[2];
`endif
                m_start[c] = e;
            end
            2'd2: begin m_period[c] = d; m_start[c] = e; end
            default: begin
`ifdef LED_CTRL_PWM_EN
                m_duty[c] = d;
`endif
                m_start[c] = e;
            end
        endcase
    endfunction

    // One bus cycle, entered and left at a falling edge; checks led and read-back every cycle.
    task automatic cyc(input logic w, input logic [15:0] a, input logic [15:0] d, input logic r);
        logic [NCH*LED_W-1:0] exp_led;
        logic [15:0]          exp_rd;
        addr = a; wdata = d; we = w; rd_en = r;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) exp_led[c*LED_W +: LED_W] = m_led(c, ecnt);
        exp_rd = m_read(a, ecnt);
        ecnt++;
        if (w) m_write(a, d, ecnt);
        #1;
        chk("led", 32'(led), 32'(exp_led));
        chk("rd_valid", 32'(rd_valid), 32'(r));
        if (r) chk("rd_data", 32'(rd_data), 32'(exp_rd));
        @(negedge clk);
        we = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rdat;
        logic        rw, rr;
        int          on_cnt;

        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; rd_en = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Static DATA write on ch0
        cyc(1'b1, BASE + 16'd0, 16'h0A5A, 1'b0);
        cyc(1'b0, BASE, 16'h0, 1'b0);
        chk("ch0_static", 32'(led[11:0]), 32'h0A5A);
        chk("ch1_quiet", 32'(led[23:12]), 32'h0);

        // ch1 blink, PERIOD=3: four cycles on, four off
        cyc(1'b1, BASE + 16'd6, 16'h0003, 1'b0);
        cyc(1'b1, BASE + 16'd4, 16'h0FFF, 1'b0);
        cyc(1'b1, BASE + 16'd5, 16'h0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, BASE, 16'h0, 1'b0);
            chk($sformatf("ch1_blink_%0d", i), 32'(led[23:12]), (i < 4) ? 32'h0FFF : 32'h0);
        end

        // ch0 PERIOD=0 blink, then inverted blink restarts at phase 1
        cyc(1'b1, BASE + 16'd2, 16'h0000, 1'b0);
        cyc(1'b1, BASE + 16'd1, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, BASE, 16'h0, 1'b0);
        cyc(1'b1, BASE + 16'd1, 16'h0003, 1'b0);
        cyc(1'b0, BASE, 16'h0, 1'b0);
        chk("ch0_inv_restart", 32'(led[11:0]), 32'h05A5);
        for (int i = 0; i < 3; i++) cyc(1'b0, BASE, 16'h0, 1'b0);

        // Same-cycle read/write, follow-up read, out-of-window read
        cyc(1'b1, BASE + 16'd2, 16'h0010, 1'b1);
        chk("rw_same_old", 32'(rd_data), 32'h0000);
        cyc(1'b0, BASE + 16'd2, 16'h0, 1'b1);
        chk("rw_next_new", 32'(rd_data), 32'h0010);
        cyc(1'b0, BASE + 16'd8, 16'h0, 1'b1);
        chk("oow_rd_data", 32'(rd_data), 32'h0);
        chk("oow_rd_valid", 32'(rd_valid), 32'h1);

        // Asynchronous reset mid-blink
        cyc(1'b0, BASE + 16'd1, 16'h0, 1'b1);
        chk("pre_rst_valid", 32'(rd_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_led", 32'(led), 32'h0);
        chk("rst_async_valid", 32'(rd_valid), 32'h0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4*NCH; i++) cyc(1'b0, BASE + 16'(i), 16'h0, 1'b1);
        cyc(1'b0, BASE + 16'd3, 16'h0, 1'b1);
        chk("status_after_rst", 32'(rd_data), 32'h0001);

`ifdef LED_CTRL_PWM_EN
        cyc(1'b1, BASE + 16'd2, 16'd9, 1'b0);
        cyc(1'b1, BASE + 16'd3, 16'd3, 1'b0);
        cyc(1'b1, BASE + 16'd0, 16'h000F, 1'b0);
        cyc(1'b1, BASE + 16'd1, 16'h0005, 1'b0);
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, BASE, 16'h0, 1'b0);
            if (led[3:0] == 4'hF) on_cnt++;
        end
        chk("pwm_on_cycles", 32'(on_cnt), 32'd6);
`else
        on_cnt = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            ra   = (($urandom % 8) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 9));
            rdat = (ra[1:0] == 2'd2) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            rw   = (($urandom % 4) == 0);
            rr   = (($urandom % 2) == 0);
            cyc(rw, ra, rdat, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
